// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared state encoding, default widths and feed-length helper
package tpu_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  localparam int OP_WIDTH  = 8;
  localparam int ACC_WIDTH = 32;

  // Cycles needed to push every skewed element of an N x N tile into the array.
  function automatic int feed_cycles(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/tile_skew_buffer.sv
// rtl/tile_skew_buffer.sv - N x N operand tile with a row-write port and a combinational skewed read
module tile_skew_buffer #(
  parameter int N         = 16,
  parameter int OP_WIDTH  = 8,
  parameter int TW        = 6,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [$clog2(N)-1:0]  wr_row,
  input  logic [N*OP_WIDTH-1:0] wr_data,
  input  logic [TW-1:0]         t,
  output logic [N*OP_WIDTH-1:0] rd_data
);

  logic [N-1:0][N-1:0][OP_WIDTH-1:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  // Lane e carries the element whose inner index k satisfies e + k == t; TRANSPOSE walks columns instead of rows.
  always_comb begin
    rd_data = '0;
    for (int e = 0; e < N; e++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t) == e + k) begin
          rd_data[e*OP_WIDTH +: OP_WIDTH] = TRANSPOSE ? mem[k][e] : mem[e][k];
        end
      end
    end
  end

endmodule

// File: rtl/mac_array_sequencer.sv
// rtl/mac_array_sequencer.sv - loads A/B tiles and sequences one output-stationary N x N multiply on the MAC array
module mac_array_sequencer #(
  parameter int N           = 16,
  parameter int OP_WIDTH    = tpu_pkg::OP_WIDTH,
  parameter int MAC_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_sel,
  input  logic [$clog2(N)-1:0]  ld_row,
  input  logic [N*OP_WIDTH-1:0] ld_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  array_clear,
  output logic [N*OP_WIDTH-1:0] a_column,
  output logic [N*OP_WIDTH-1:0] b_row
);
  import tpu_pkg::*;

  localparam int TW = $clog2(feed_cycles(N) + MAC_LATENCY + 1);
  localparam logic [TW-1:0] FEED_END  = TW'(feed_cycles(N) - 1);
  localparam logic [TW-1:0] DRAIN_END = TW'(MAC_LATENCY);

  state_t                state, state_n;
  logic [TW-1:0]         t, t_n;
  logic [N*OP_WIDTH-1:0] a_skew, b_skew;
  logic                  load_en;

  assign ld_ready = (state == IDLE);
  assign load_en  = ld_valid && ld_ready;

  tile_skew_buffer #(.N(N), .OP_WIDTH(OP_WIDTH), .TW(TW), .TRANSPOSE(1'b0)) u_tile_a (
    .clk(clk), .reset(reset), .wr_en(load_en && !ld_sel), .wr_row(ld_row),
    .wr_data(ld_data), .t(t_n), .rd_data(a_skew)
  );

  tile_skew_buffer #(.N(N), .OP_WIDTH(OP_WIDTH), .TW(TW), .TRANSPOSE(1'b1)) u_tile_b (
    .clk(clk), .reset(reset), .wr_en(load_en && ld_sel), .wr_row(ld_row),
    .wr_data(ld_data), .t(t_n), .rd_data(b_skew)
  );

  // t doubles as the feed index and the drain counter.
  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      IDLE:  if (start) state_n = CLEAR;
      CLEAR: begin
        state_n = FEED;
        t_n     = '0;
      end
      FEED: begin
        if (t == FEED_END) begin
          state_n = DRAIN;
          t_n     = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      DRAIN: begin
        if (t == DRAIN_END) begin
          state_n = DONE;
          t_n     = '0;
        end else begin
          t_n = t + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      t           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_clear <= 1'b0;
      a_column    <= '0;
      b_row       <= '0;
    end else begin
      state       <= state_n;
      t           <= t_n;
      busy        <= (state_n == CLEAR) || (state_n == FEED) || (state_n == DRAIN);
      done        <= (state_n == DONE);
      array_clear <= (state_n == CLEAR);
      a_column    <= (state_n == FEED) ? a_skew : '0;
      b_row       <= (state_n == FEED) ? b_skew : '0;
    end
  end

endmodule
